// File: rtl/io_6s46_pkg.sv
// Shared constants for the 6S46 I/O segment: register addresses, timer factor taps, default clock.
package io_6s46_pkg;

  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned DATA_W   = 4;
  localparam int unsigned TM_W     = 8;
  localparam int unsigned NUM_FACT = 4;

  localparam int unsigned DEFAULT_CLK_HZ = 32768;

  localparam logic [ADDR_W-1:0] IO_IT    = 12'hF00;
  localparam logic [ADDR_W-1:0] IO_IK0   = 12'hF04;
  localparam logic [ADDR_W-1:0] IO_EIT   = 12'hF10;
  localparam logic [ADDR_W-1:0] IO_EIK0  = 12'hF14;
  localparam logic [ADDR_W-1:0] IO_TM_LO = 12'hF20;
  localparam logic [ADDR_W-1:0] IO_TM_HI = 12'hF21;
  localparam logic [ADDR_W-1:0] IO_K0    = 12'hF40;
  localparam logic [ADDR_W-1:0] IO_TMRST = 12'hF76;

  // TM bit whose falling edge raises each IT factor
  localparam int unsigned TM_BIT_32HZ = 2;
  localparam int unsigned TM_BIT_8HZ  = 4;
  localparam int unsigned TM_BIT_2HZ  = 6;
  localparam int unsigned TM_BIT_1HZ  = 7;

  // Position of each factor inside IT
  localparam int unsigned IT_BIT_32HZ = 0;
  localparam int unsigned IT_BIT_8HZ  = 1;
  localparam int unsigned IT_BIT_2HZ  = 2;
  localparam int unsigned IT_BIT_1HZ  = 3;

  // Factor-set vector for a TM transition old -> new (1 where a tap bit falls)
  function automatic logic [NUM_FACT-1:0] fact_fall(input logic [TM_W-1:0] tm_old,
                                                    input logic [TM_W-1:0] tm_new);
    logic [NUM_FACT-1:0] f;
    f              = '0;
    f[IT_BIT_32HZ] = tm_old[TM_BIT_32HZ] & ~tm_new[TM_BIT_32HZ];
    f[IT_BIT_8HZ]  = tm_old[TM_BIT_8HZ]  & ~tm_new[TM_BIT_8HZ];
    f[IT_BIT_2HZ]  = tm_old[TM_BIT_2HZ]  & ~tm_new[TM_BIT_2HZ];
    f[IT_BIT_1HZ]  = tm_old[TM_BIT_1HZ]  & ~tm_new[TM_BIT_1HZ];
    return f;
  endfunction

endpackage

// File: rtl/io_interrupt_responder_clock_timer.sv
// clock_timer_6s46: tick divider, 8-bit TM counter with clear, and factor-set pulses
// derived from TM tap bits falling (including falls caused by a clear).
module clock_timer_6s46
  import io_6s46_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEFAULT_CLK_HZ / 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_clr,
  output logic [TM_W-1:0]     o_tm,
  output logic [NUM_FACT-1:0] o_set_c
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic [TM_W-1:0]  r_tm;
  logic [DIV_W-1:0] w_div_next;
  logic [TM_W-1:0]  w_tm_next;

  // Next divider/TM value; clear has priority over a tick
  always_comb begin
    w_div_next = r_div + DIV_W'(1);
    w_tm_next  = r_tm;
    if (i_clr) begin
      w_div_next = '0;
      w_tm_next  = '0;
    end else if (r_div == DIV_LAST) begin
      w_div_next = '0;
      w_tm_next  = r_tm + TM_W'(1);
    end
  end

  // Divider and TM state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= '0;
      r_tm  <= '0;
    end else begin
      r_div <= w_div_next;
      r_tm  <= w_tm_next;
    end
  end

  assign o_tm    = r_tm;
  assign o_set_c = fact_fall(r_tm, w_tm_next);

endmodule

// File: rtl/io_interrupt_responder.sv
// io_interrupt_responder: 6S46 I/O segment (0xF00-0xFFF) bus responder with clock timer,
// IT/EIT interrupt registers, K0 input port and the core's level interrupt request.
// Optional macro IO_K0_INTERRUPT_EN enables K0 falling-edge interrupts (IK0/EIK0).
module io_interrupt_responder
  import io_6s46_pkg::*;
#(
  parameter int unsigned CLK_HZ   = DEFAULT_CLK_HZ,
  parameter int unsigned TICK_DIV = CLK_HZ / 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] memory_addr,
  input  logic              memory_write_en,
  input  logic [DATA_W-1:0] memory_write_data,
  output logic [DATA_W-1:0] memory_read_data,
  output logic              io_read_hit,
  input  logic [3:0]        k0_in,
  output logic              interrupt_req
);

  logic                w_sel;
  logic                w_rd;
  logic                w_wr;
  logic                w_clr;
  logic [TM_W-1:0]     w_tm;
  logic [NUM_FACT-1:0] w_set;
  logic [DATA_W-1:0]   w_rd_val;
  logic [DATA_W-1:0]   w_ik0_rd;
  logic [DATA_W-1:0]   w_eik0_rd;
  logic                w_k0_irq;
  logic                w_irq_c;

  logic [NUM_FACT-1:0] r_it;
  logic [NUM_FACT-1:0] r_eit;
  logic [3:0]          r_k0_s1;
  logic [3:0]          r_k0_s2;

  assign w_sel = (memory_addr[11:8] == 4'hF);
  assign w_rd  = w_sel & ~memory_write_en;
  assign w_wr  = w_sel &  memory_write_en;
  assign w_clr = w_wr & (memory_addr == IO_TMRST) & memory_write_data[1];

  clock_timer_6s46 #(
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_clr),
    .o_tm    (w_tm),
    .o_set_c (w_set)
  );

  // Read mux; unmapped and write-only addresses return 0
  always_comb begin
    w_rd_val = '0;
    case (memory_addr)
      IO_IT:    w_rd_val = r_it;
      IO_IK0:   w_rd_val = w_ik0_rd;
      IO_EIT:   w_rd_val = r_eit;
      IO_EIK0:  w_rd_val = w_eik0_rd;
      IO_TM_LO: w_rd_val = w_tm[3:0];
      IO_TM_HI: w_rd_val = w_tm[7:4];
      IO_K0:    w_rd_val = r_k0_s2;
      default:  w_rd_val = '0;
    endcase
  end

  // Bus read port, IT read-clear with set priority, EIT mask and K0 synchroniser
  always_ff @(posedge clk) begin
    if (reset) begin
      memory_read_data <= '0;
      io_read_hit      <= 1'b0;
      r_it             <= '0;
      r_eit            <= '0;
      r_k0_s1          <= 4'hF;
      r_k0_s2          <= 4'hF;
    end else begin
      io_read_hit <= w_rd;
      if (w_rd) begin
        memory_read_data <= w_rd_val;
      end
      r_it <= ((w_rd && (memory_addr == IO_IT)) ? '0 : r_it) | w_set;
      if (w_wr && (memory_addr == IO_EIT)) begin
        r_eit <= memory_write_data;
      end
      r_k0_s1 <= k0_in;
      r_k0_s2 <= r_k0_s1;
    end
  end

`ifdef IO_K0_INTERRUPT_EN
  logic [3:0] r_k0_d;
  logic       r_ik0;
  logic       r_eik0;
  logic       w_k0_fall;

  assign w_k0_fall = |(r_k0_d & ~r_k0_s2);

  // K0 falling-edge factor (read-clear, set wins) and its mask
  always_ff @(posedge clk) begin
    if (reset) begin
      r_k0_d <= 4'hF;
      r_ik0  <= 1'b0;
      r_eik0 <= 1'b0;
    end else begin
      r_k0_d <= r_k0_s2;
      r_ik0  <= ((w_rd && (memory_addr == IO_IK0)) ? 1'b0 : r_ik0) | w_k0_fall;
      if (w_wr && (memory_addr == IO_EIK0)) begin
        r_eik0 <= memory_write_data[0];
      end
    end
  end

  assign w_ik0_rd  = {3'b000, r_ik0};
  assign w_eik0_rd = {3'b000, r_eik0};
  assign w_k0_irq  = r_ik0 & r_eik0;
`else
  assign w_ik0_rd  = '0;
  assign w_eik0_rd = '0;
  assign w_k0_irq  = 1'b0;
`endif

  assign w_irq_c = (|(r_it & r_eit)) | w_k0_irq;

  // Registered level interrupt request
  always_ff @(posedge clk) begin
    if (reset) begin
      interrupt_req <= 1'b0;
    end else begin
      interrupt_req <= w_irq_c;
    end
  end

endmodule

// File: tb/tb_io_interrupt_responder.sv
// Bench for io_interrupt_responder (TICK_DIV=4): constant vector table, hand-timed
// timer/K0/reset sequences, and randomized traffic against a cycle reference model.
module tb_io_interrupt_responder;

  localparam int unsigned TDIV = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] addr;
  logic        we;
  logic [3:0]  wd;
  logic [3:0]  rdata;
  logic        hit;
  logic [3:0]  k0;
  logic        irq;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc_n  = 0;

  // reference model state
  int         m_tm, m_div;
  logic [3:0] m_it, m_eit, m_rdata;
  logic       m_ik0, m_eik0, m_hit, m_irq;
  logic [3:0] ks [3];   // ks[0]: k0 sampled last edge, ks[1]: two edges ago, ks[2]: three

  io_interrupt_responder #(
    .CLK_HZ   (1024),
    .TICK_DIV (TDIV)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .memory_addr       (addr),
    .memory_write_en   (we),
    .memory_write_data (wd),
    .memory_read_data  (rdata),
    .io_read_hit       (hit),
    .k0_in             (k0),
    .interrupt_req     (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: cycle %0d got %h expected %h", name, cyc_n, got, exp);
    end
  endtask

  function automatic logic [3:0] model_read(input logic [11:0] a);
    case (a)
      12'hF00: return m_it;
`ifdef IO_K0_INTERRUPT_EN
      12'hF04: return {3'b000, m_ik0};
      12'hF14: return {3'b000, m_eik0};
`endif
      12'hF10: return m_eit;
      12'hF20: return 4'(m_tm % 16);
      12'hF21: return 4'(m_tm / 16);
      12'hF40: return ks[1];
      default: return 4'h0;
    endcase
  endfunction

  // Advance the reference model by one clock edge using the applied inputs
  task automatic model_step();
    int         old_tm;
    int         fb [4] = '{2, 4, 6, 7};
    logic [3:0] set;
    logic [3:0] fall;
    logic       sel, rd, wr, irq_n;
    if (reset) begin
      m_tm = 0; m_div = 0; m_it = 0; m_eit = 0; m_ik0 = 0; m_eik0 = 0;
      m_rdata = 0; m_hit = 0; m_irq = 0;
      for (int i = 0; i < 3; i++) ks[i] = 4'hF;
      return;
    end
    irq_n = (|(m_it & m_eit)) | (m_ik0 & m_eik0);
    sel = (addr[11:8] == 4'hF);
    rd  = sel && !we;
    wr  = sel && we;
    if (rd) m_rdata = model_read(addr);
    m_hit = rd;
    old_tm = m_tm;
    if (wr && addr == 12'hF76 && wd[1]) begin
      m_tm = 0; m_div = 0;
    end else begin
      m_div++;
      if (m_div == TDIV) begin
        m_div = 0;
        m_tm  = (m_tm + 1) % 256;
      end
    end
    for (int i = 0; i < 4; i++)
      set[i] = (((old_tm >> fb[i]) & 1) == 1) && (((m_tm >> fb[i]) & 1) == 0);
    m_it = ((rd && addr == 12'hF00) ? 4'h0 : m_it) | set;
    fall = ks[2] & ~ks[1];
    ks[2] = ks[1]; ks[1] = ks[0]; ks[0] = k0;
`ifdef IO_K0_INTERRUPT_EN
    m_ik0 = ((rd && addr == 12'hF04) ? 1'b0 : m_ik0) | (|fall);
    if (wr && addr == 12'hF14) m_eik0 = wd[0];
`endif
    if (wr && addr == 12'hF10) m_eit = wd;
    m_irq = irq_n;
  endtask

  // One bus cycle: drive at negedge, clock, then compare against the model
  task automatic cyc(input logic [11:0] a, input logic w, input logic [3:0] d);
    addr = a; we = w; wd = d;
    @(posedge clk);
    model_step();
    cyc_n++;
    @(negedge clk);
    chk("model_rdata", rdata, m_rdata);
    chk("model_hit", {3'b000, hit}, {3'b000, m_hit});
    chk("model_irq", {3'b000, irq}, {3'b000, m_irq});
  endtask

  task automatic idle();
    cyc(12'h000, 1'b0, 4'h0);
  endtask

  task automatic run_to(input int e);
    while (cyc_n < e) idle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    k0 = 4'hF;
    repeat (3) idle();
    reset = 1'b0;
    cyc_n = 0;
  endtask

  typedef struct {
    logic [11:0] a;
    logic        w;
    logic [3:0]  d;
    logic [3:0]  exp_rd;
    logic        exp_hit;
  } vec_t;

  vec_t tbl [13];

  initial begin
    logic [3:0] eik0_exp;
    logic [11:0] alist [8] = '{12'hF00, 12'hF04, 12'hF10, 12'hF14,
                               12'hF20, 12'hF21, 12'hF40, 12'hF76};
`ifdef IO_K0_INTERRUPT_EN
    eik0_exp = 4'h1;
`else
    eik0_exp = 4'h0;
`endif
    tbl[0]  = '{12'hF00, 1'b0, 4'h0, 4'h0, 1'b1};
    tbl[1]  = '{12'hF10, 1'b0, 4'h0, 4'h0, 1'b1};
    tbl[2]  = '{12'hF20, 1'b0, 4'h0, 4'h0, 1'b1};
    tbl[3]  = '{12'hF40, 1'b0, 4'h0, 4'hF, 1'b1};
    tbl[4]  = '{12'hF21, 1'b0, 4'h0, 4'h0, 1'b1};
    tbl[5]  = '{12'hF04, 1'b0, 4'h0, 4'h0, 1'b1};
    tbl[6]  = '{12'hF76, 1'b0, 4'h0, 4'h0, 1'b1};
    tbl[7]  = '{12'h3F0, 1'b0, 4'h0, 4'h0, 1'b0};
    tbl[8]  = '{12'hF10, 1'b1, 4'hA, 4'h0, 1'b0};
    tbl[9]  = '{12'hF10, 1'b0, 4'h0, 4'hA, 1'b1};
    tbl[10] = '{12'hF14, 1'b1, 4'hF, 4'hA, 1'b0};
    tbl[11] = '{12'hF14, 1'b0, 4'h0, eik0_exp, 1'b1};
    tbl[12] = '{12'hF10, 1'b1, 4'h0, eik0_exp, 1'b0};

    addr = 12'h000; we = 1'b0; wd = 4'h0;
    do_reset();
    chk("reset_rdata", rdata, 4'h0);
    chk("reset_hit", {3'b000, hit}, 4'h0);
    chk("reset_irq", {3'b000, irq}, 4'h0);

    // constant vectors right after reset (TM still 0/1, no factors yet)
    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].a, tbl[i].w, tbl[i].d);
      chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_hit", i), {3'b000, hit}, {3'b000, tbl[i].exp_hit});
      chk($sformatf("tbl%0d_irq", i), {3'b000, irq}, 4'h0);
    end

    // timer factors, mask, read-clear collision and TM clear
    do_reset();
    run_to(32);
    cyc(12'hF00, 1'b0, 4'h0); chk("it_first_32hz", rdata, 4'h1);
    cyc(12'hF00, 1'b0, 4'h0); chk("it_cleared", rdata, 4'h0);
    cyc(12'hF10, 1'b1, 4'h1);
    run_to(64);               chk("irq_same_edge", {3'b000, irq}, 4'h0);
    idle();                   chk("irq_lag1", {3'b000, irq}, 4'h1);
    cyc(12'hF00, 1'b0, 4'h0); chk("it_masked_read", rdata, 4'h1);
                              chk("irq_hold", {3'b000, irq}, 4'h1);
    idle();                   chk("irq_drop", {3'b000, irq}, 4'h0);
    run_to(95);
    cyc(12'hF00, 1'b0, 4'h0); chk("collide_old", rdata, 4'h0);
    cyc(12'hF00, 1'b0, 4'h0); chk("collide_set_wins", rdata, 4'h1);
    run_to(512);
    cyc(12'hF76, 1'b1, 4'h2);
    cyc(12'hF20, 1'b0, 4'h0); chk("tm_lo_clr", rdata, 4'h0);
    cyc(12'hF21, 1'b0, 4'h0); chk("tm_hi_clr", rdata, 4'h0);
    cyc(12'hF00, 1'b0, 4'h0); chk("it_after_clr", rdata, 4'hF);

    // K0 falling edge
    do_reset();
    cyc(12'hF14, 1'b1, 4'h1);
    k0 = 4'b1011;
    idle();
    idle();
    idle();                   chk("k0_irq_early", {3'b000, irq}, 4'h0);
    cyc(12'hF04, 1'b0, 4'h0);
`ifdef IO_K0_INTERRUPT_EN
    chk("ik0_set", rdata, 4'h1);
    chk("k0_irq", {3'b000, irq}, 4'h1);
`else
    chk("ik0_off", rdata, 4'h0);
    chk("k0_irq_off", {3'b000, irq}, 4'h0);
`endif
    cyc(12'hF40, 1'b0, 4'h0); chk("k0_port", rdata, 4'b1011);
    k0 = 4'hF;
    repeat (4) idle();
    cyc(12'hF04, 1'b0, 4'h0); chk("ik0_rise_ignored", rdata, 4'h0);

    // reset mid-operation
    do_reset();
    cyc(12'hF10, 1'b1, 4'hF);
    run_to(33);               chk("pre_rst_irq", {3'b000, irq}, 4'h1);
    reset = 1'b1;
    idle();                   chk("rst_irq", {3'b000, irq}, 4'h0);
    reset = 1'b0;
    cyc(12'hF00, 1'b0, 4'h0); chk("rst_it_gone", rdata, 4'h0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [11:0] a;
      logic [3:0]  d;
      logic        w;
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) == 0) k0 = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 9))
        8:       a = 12'($urandom_range(0, 4095));
        9:       a = 12'hF00 | 12'($urandom_range(0, 255));
        default: a = alist[$urandom_range(0, 7)];
      endcase
      w = ($urandom_range(0, 9) < 3);
      d = 4'($urandom_range(0, 15));
      if (a == 12'hF76 && $urandom_range(0, 7) != 0) d = d & 4'hD;
      cyc(a, w, d);
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
